load_store_unit: RTL

- Initiator side of the word-wide data memory port (memread/memwrite/address/write_data/read_data).
- Sits between the core's execute stage and data memory.
- Accepts one RV32I load or store per handshake. Performs sub-word stores as read-modify-write, then returns a sign- or zero-extended load result or a completion.
- Flags misaligned, out-of-range and illegal-funct3 requests without touching memory.

---
 rtl/load_store_unit_if.sv | 36 +++
 rtl/load_store_unit.sv | 133 +++++++++++++
 2 files changed

// File: rtl/load_store_unit_if.sv
// Core-side request/response handshake plus the word-wide data memory port
// of the load/store unit. The LSU takes the slave view; the core/memory
// environment takes the master view.
interface load_store_unit_if;
    // request from the execute stage
    logic        req_valid;
    logic        req_ready;
    logic        req_is_store;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    // completion back to the core
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    // data memory port (LSU is the initiator)
    logic        mem_memread;
    logic        mem_memwrite;
    logic [31:0] mem_address;
    logic [31:0] mem_write_data;
    logic [31:0] mem_read_data;

    modport slave (
        input  req_valid, req_is_store, req_funct3, req_addr, req_wdata,
        input  mem_read_data,
        output req_ready, resp_valid, resp_rdata, resp_err,
        output mem_memread, mem_memwrite, mem_address, mem_write_data
    );

    modport master (
        output req_valid, req_is_store, req_funct3, req_addr, req_wdata,
        output mem_read_data,
        input  req_ready, resp_valid, resp_rdata, resp_err,
        input  mem_memread, mem_memwrite, mem_address, mem_write_data
    );
endinterface

// File: rtl/load_store_unit.sv
// RV32I load/store unit: one request at a time, sub-word stores done as
// read-modify-write on a word-wide memory, loads returned extended.
// Bad requests (illegal funct3, misaligned, out of range) are answered
// with resp_err without any memory access.
module load_store_unit #(
    parameter int unsigned MEM_BYTES = 128
) (
    input  logic               clk,
    input  logic               reset_n,
    load_store_unit_if.slave   bus
);

    typedef enum logic [2:0] {IDLE, LOAD, RMW_RD, WRITE, RESP} state_t;

    state_t      state;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [2:0]  funct3_q;
    logic        is_store_q;
    logic        err_q;
    logic [31:0] word_q;   // word to write: SW data or merged RMW word
    logic [31:0] rdata_q;  // extended load result

    logic        req_err;
    logic        f3_bad;
    logic        misaligned;
    logic        out_of_range;
    logic [31:0] rd_shift;
    logic [31:0] load_val;
    logic [31:0] merged;

    // Classify the incoming request; only meaningful while in IDLE.
    always_comb begin
        if (bus.req_is_store)
            f3_bad = (bus.req_funct3 >= 3'd3);
        else
            f3_bad = (bus.req_funct3 == 3'd3) || (bus.req_funct3 == 3'd6) ||
                     (bus.req_funct3 == 3'd7);
        misaligned = ((bus.req_funct3[1:0] == 2'd1) && bus.req_addr[0]) ||
                     ((bus.req_funct3[1:0] == 2'd2) && (bus.req_addr[1:0] != 2'd0));
        out_of_range = (bus.req_addr >= 32'(MEM_BYTES));
        req_err = f3_bad || misaligned || out_of_range;
    end

    // Select the addressed lane of the read word and extend it.
    always_comb begin
        rd_shift = bus.mem_read_data >> {addr_q[1:0], 3'b000};
        case (funct3_q)
            3'd0:    load_val = {{24{rd_shift[7]}}, rd_shift[7:0]};
            3'd1:    load_val = {{16{rd_shift[15]}}, rd_shift[15:0]};
            3'd4:    load_val = {24'd0, rd_shift[7:0]};
            3'd5:    load_val = {16'd0, rd_shift[15:0]};
            default: load_val = bus.mem_read_data;
        endcase
    end

    // Splice the store byte/half into the word read back from memory.
    always_comb begin
        merged = bus.mem_read_data;
        if (funct3_q[1:0] == 2'd0) begin
            case (addr_q[1:0])
                2'd0: merged[7:0]   = wdata_q[7:0];
                2'd1: merged[15:8]  = wdata_q[7:0];
                2'd2: merged[23:16] = wdata_q[7:0];
                2'd3: merged[31:24] = wdata_q[7:0];
            endcase
        end else begin
            if (addr_q[1])
                merged[31:16] = wdata_q[15:0];
            else
                merged[15:0]  = wdata_q[15:0];
        end
    end

    // Control FSM with latched request fields and result registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            addr_q     <= '0;
            wdata_q    <= '0;
            funct3_q   <= '0;
            is_store_q <= 1'b0;
            err_q      <= 1'b0;
            word_q     <= '0;
            rdata_q    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        addr_q     <= bus.req_addr;
                        wdata_q    <= bus.req_wdata;
                        funct3_q   <= bus.req_funct3;
                        is_store_q <= bus.req_is_store;
                        err_q      <= req_err;
                        word_q     <= bus.req_wdata;
                        rdata_q    <= '0;
                        if (req_err)
                            state <= RESP;
                        else if (!bus.req_is_store)
                            state <= LOAD;
                        else if (bus.req_funct3 == 3'd2)
                            state <= WRITE;
                        else
                            state <= RMW_RD;
                    end
                end
                LOAD: begin
                    rdata_q <= load_val;
                    state   <= RESP;
                end
                RMW_RD: begin
                    word_q <= merged;
                    state  <= WRITE;
                end
                WRITE:   state <= RESP;
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Outputs are pure decodes of registered state, so reset clears them at once.
    assign bus.req_ready      = (state == IDLE);
    assign bus.resp_valid     = (state == RESP);
    assign bus.resp_err       = (state == RESP) && err_q;
    assign bus.resp_rdata     = ((state == RESP) && !is_store_q) ? rdata_q : 32'd0;
    assign bus.mem_memread    = (state == LOAD) || (state == RMW_RD);
    assign bus.mem_memwrite   = (state == WRITE);
    assign bus.mem_address    = ((state == LOAD) || (state == RMW_RD) || (state == WRITE)) ?
                                {addr_q[31:2], 2'b00} : 32'd0;
    assign bus.mem_write_data = (state == WRITE) ? word_q : 32'd0;

endmodule
